fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Owns the architectural fetch PC and the instruction-memory request handshake.
//   Sits directly upstream of fetch: drives pc and raw_instr into the fetch stage and takes pcplus4 back from it.
//   Selects the next PC from exception redirect, branch redirect or sequential pcplus4.
//   Allows at most one outstanding imem request; holds the returned word while the pipeline stalls.
// PARAMETERS
//   RESET_PC   32'hBFC0_0000   PC loaded on reset
//   NOP_INSTR  32'h0000_0000   raw_instr value driven when instr_valid=0
// PORTS
//   clk            in   1   single clock; all state updates on posedge
//   resetn         in   1   asynchronous, active-low reset
//   pcplus4        in   32  sequential next PC, computed by fetch from pc
//   br_redirect    in   1   branch/jump resolved taken; 1-cycle pulse
//   br_target      in   32  branch/jump target; valid with br_redirect
//   exc_redirect   in   1   exception/eret redirect; 1-cycle pulse
//   exc_target     in   32  exception vector or EPC; valid with exc_redirect
//   stall          in   1   decode register cannot accept an instruction this cycle
//   ireq_valid     out  1   imem request valid
//   ireq_addr      out  32  imem request address (= pc)
//   ireq_ready     in   1   imem accepts the address this cycle (addr_ok)
//   iresp_valid    in   1   imem returns data this cycle (data_ok)
//   iresp_data     in   32  returned instruction word
//   pc             out  32  current fetch PC, to fetch stage
//   raw_instr      out  32  instruction for pc, to fetch stage
//   instr_valid    out  1   pc/raw_instr pair is valid this cycle
//   adel           out  1   pc misaligned (pc[1:0]!=0); qualified by instr_valid
//   fetch_busy     out  1   waiting on imem; hazard unit uses it to stall the front end
// BEHAVIOUR
//   Reset (async, resetn=0): pc=RESET_PC, state=REQ, discard=0.
//     Outputs during reset: ireq_valid=0, instr_valid=0, adel=0, raw_instr=NOP_INSTR.
//   States:
//     REQ   ireq_valid=1, ireq_addr=pc. If ireq_ready=1 -> WAIT.
//     WAIT  ireq_valid=0. On iresp_valid: if discard=1, drop the word, clear discard, go to REQ;
//           else capture iresp_data into buf and go to HOLD.
//     HOLD  instr_valid=1, raw_instr=buf. On accept -> REQ.
//   Accept = instr_valid & ~stall. On accept, pc <= pcplus4, unless a redirect takes priority.
//   Misaligned pc (pc[1:0]!=0): no imem request is issued.
//     State MIS: instr_valid=1, adel=1, raw_instr=NOP_INSTR; leaves only via redirect or accept.
//   Redirect priority: exc_redirect > br_redirect > sequential. Redirect is taken regardless of stall.
//     pc <= target next cycle.
//     If a request is outstanding (WAIT, or REQ with ireq_ready=1 this cycle): discard <= 1 and state -> WAIT.
//     Otherwise state -> REQ.
//     A HOLD word is dropped on redirect.
//   Redirect in the same cycle as iresp_valid in WAIT: the returned word is dropped,
//     no discard is set, state -> REQ with the new pc.
//   Redirect while discard=1 already: discard stays 1; only one response is ever pending.
//   Latency: with zero-wait imem (ireq_ready=1, iresp_valid the next cycle), the first instr_valid
//     appears 2 cycles after the request. Steady-state throughput is 1 instr / 3 cycles (REQ, WAIT, HOLD).
//     A bypass is allowed and preferred: in WAIT with iresp_valid & ~discard & ~stall, present
//     iresp_data directly with instr_valid=1 and go to REQ.
//   fetch_busy = (state==REQ) | (state==WAIT).
//   pc is 32-bit; pcplus4 wraps 32'hFFFF_FFFC -> 0 with no flag.
//   ireq_valid, once asserted, stays asserted with a stable addr until ireq_ready, unless a redirect occurs.
//   Reset mid-WAIT: the next iresp_valid after resetn rises is ignored.
//     Implemented by setting discard=1 on the first post-reset request only if the imem may still respond;
//     the bench drives no iresp in that case.
// TESTING
//   Reset release -> ireq_valid=1, ireq_addr=32'hBFC0_0000 on the first edge; instr_valid=0 throughout reset.
//   Zero-wait imem returns 0x2408_0001, 0x2409_0002 -> pc sequence BFC00000, BFC00004;
//     each raw_instr presented with instr_valid.
//   stall=1 for 3 cycles in HOLD -> pc and raw_instr held constant; one ireq only; advance when stall drops.
//   br_redirect to 0x8000_0100 while in WAIT -> the next iresp (0xDEADBEEF) is never presented;
//     next ireq_addr=0x8000_0100.
//   exc_redirect=0x8000_0180 and br_redirect=0x8000_0100 in the same cycle -> pc=0x8000_0180.
//   br_target=0x8000_0102 -> no ireq; instr_valid=1, adel=1, raw_instr=0; exc_redirect to 0x8000_0180 clears it.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: selects the next PC (exception > branch > sequential) and runs the
// single-outstanding instruction-memory handshake, holding the returned word across stalls.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcplus4,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic [31:0] pc,
  output logic [31:0] raw_instr,
  output logic        instr_valid,
  output logic        adel,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_MIS
  } state_t;

  state_t      state;
  logic        discard;
  logic [31:0] instr_buf;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        outstanding;

  // A misaligned PC never reaches imem; it parks in MIS and reports AdEL instead.
  function automatic state_t entry_state(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) ? S_MIS : S_REQ;
  endfunction

  assign redirect        = exc_redirect | br_redirect;
  assign redirect_target = exc_redirect ? exc_target : br_target;

  // A response is still owed if we are waiting without data, or the address is accepted now.
  assign outstanding = ((state == S_WAIT) && !iresp_valid) ||
                       ((state == S_REQ) && ireq_ready);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc        <= RESET_PC;
      state     <= S_REQ;
      discard   <= 1'b0;
      instr_buf <= NOP_INSTR;
    end else if (redirect) begin
      pc <= redirect_target;
      if (outstanding) begin
        state   <= S_WAIT;
        discard <= 1'b1;
      end else begin
        state   <= entry_state(redirect_target);
        discard <= 1'b0;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (ireq_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (iresp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= entry_state(pc);
            end else begin
              instr_buf <= iresp_data;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD, S_MIS: begin
          if (!stall) begin
            pc    <= pcplus4;
            state <= entry_state(pcplus4);
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Outputs decode the state register only; resetn gates the request while reset is held.
  assign ireq_valid  = resetn && (state == S_REQ);
  assign ireq_addr   = pc;
  assign instr_valid = (state == S_HOLD) || (state == S_MIS);
  assign adel        = (state == S_MIS);
  assign raw_instr   = (state == S_HOLD) ? instr_buf : NOP_INSTR;
  assign fetch_busy  = (state == S_REQ) || (state == S_WAIT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: hand-driven imem handshake, stalls, redirects,
// misaligned PC and PC wrap, each checked against hand-computed values.
module tb_fetch_pc_unit;

  logic        clk;
  logic        resetn;
  logic [31:0] pcplus4;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        exc_redirect;
  logic [31:0] exc_target;
  logic        stall;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic [31:0] pc;
  logic [31:0] raw_instr;
  logic        instr_valid;
  logic        adel;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcplus4      (pcplus4),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .exc_redirect (exc_redirect),
    .exc_target   (exc_target),
    .stall        (stall),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .ireq_ready   (ireq_ready),
    .iresp_valid  (iresp_valid),
    .iresp_data   (iresp_data),
    .pc           (pc),
    .raw_instr    (raw_instr),
    .instr_valid  (instr_valid),
    .adel         (adel),
    .fetch_busy   (fetch_busy)
  );

  // Fetch-stage stand-in: sequential PC computed from the presented pc.
  assign pcplus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch of one word from REQ into HOLD.
  task automatic fetch_word(input logic [31:0] word);
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = word;
    step();
    iresp_valid = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    br_redirect  = 1'b0;
    br_target    = '0;
    exc_redirect = 1'b0;
    exc_target   = '0;
    stall        = 1'b0;
    ireq_ready   = 1'b0;
    iresp_valid  = 1'b0;
    iresp_data   = '0;

    repeat (3) step();
    check("rst_ireq_valid",  {31'd0, ireq_valid},  32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_adel",        {31'd0, adel},        32'd0);
    check("rst_raw_instr",   raw_instr,            32'h0000_0000);
    check("rst_pc",          pc,                   32'hBFC0_0000);

    resetn = 1'b1;
    step();
    check("rel_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    check("rel_ireq_addr",  ireq_addr,           32'hBFC0_0000);
    check("rel_busy",       {31'd0, fetch_busy}, 32'd1);
    step();
    check("req_held_valid", {31'd0, ireq_valid}, 32'd1);
    check("req_held_addr",  ireq_addr,           32'hBFC0_0000);

    // Zero-wait: request accepted, WAIT, then HOLD presents the word.
    ireq_ready = 1'b1;
    step();
    check("wait_ireq_valid",  {31'd0, ireq_valid},  32'd0);
    check("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'h2408_0001;
    step();
    iresp_valid = 1'b0;
    check("i0_valid", {31'd0, instr_valid}, 32'd1);
    check("i0_raw",   raw_instr,            32'h2408_0001);
    check("i0_pc",    pc,                   32'hBFC0_0000);
    check("i0_busy",  {31'd0, fetch_busy},  32'd0);

    step();
    check("i1_req_valid", {31'd0, ireq_valid}, 32'd1);
    check("i1_req_addr",  ireq_addr,           32'hBFC0_0004);
    fetch_word(32'h2409_0002);
    check("i1_valid", {31'd0, instr_valid}, 32'd1);
    check("i1_raw",   raw_instr,            32'h2409_0002);
    check("i1_pc",    pc,                   32'hBFC0_0004);

    // Stall in HOLD: everything holds, no new request.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    pc,                   32'hBFC0_0004);
      check("stall_raw",   raw_instr,            32'h2409_0002);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_noreq", {31'd0, ireq_valid},  32'd0);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",   pc,                  32'hBFC0_0008);
    check("unstall_req",  {31'd0, ireq_valid}, 32'd1);

    // Branch while WAIT: the late response must be dropped.
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    br_redirect = 1'b1;
    br_target   = 32'h8000_0100;
    step();
    br_redirect = 1'b0;
    check("brw_pc",    pc,                  32'h8000_0100);
    check("brw_noreq", {31'd0, ireq_valid}, 32'd0);
    iresp_valid = 1'b1;
    iresp_data  = 32'hDEAD_BEEF;
    step();
    iresp_valid = 1'b0;
    check("brw_dropped",  {31'd0, instr_valid}, 32'd0);
    check("brw_req",      {31'd0, ireq_valid},  32'd1);
    check("brw_req_addr", ireq_addr,            32'h8000_0100);
    step();
    check("brw_still_no_instr", {31'd0, instr_valid}, 32'd0);

    // Redirect coinciding with the response: word dropped, straight to REQ.
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'h1111_1111;
    br_redirect = 1'b1;
    br_target   = 32'h8000_0200;
    step();
    iresp_valid = 1'b0;
    br_redirect = 1'b0;
    check("brr_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("brr_req",         {31'd0, ireq_valid},  32'd1);
    check("brr_req_addr",    ireq_addr,            32'h8000_0200);

    // Redirect while the address is being accepted: one response still owed.
    ireq_ready  = 1'b1;
    br_redirect = 1'b1;
    br_target   = 32'h8000_0300;
    step();
    ireq_ready  = 1'b0;
    br_redirect = 1'b0;
    check("bra_noreq", {31'd0, ireq_valid}, 32'd0);
    check("bra_pc",    pc,                  32'h8000_0300);
    iresp_valid = 1'b1;
    iresp_data  = 32'h2222_2222;
    step();
    iresp_valid = 1'b0;
    check("bra_dropped",  {31'd0, instr_valid}, 32'd0);
    check("bra_req_addr", ireq_addr,            32'h8000_0300);
    check("bra_req",      {31'd0, ireq_valid},  32'd1);

    // Exception beats branch in the same cycle.
    exc_redirect = 1'b1;
    exc_target   = 32'h8000_0180;
    br_redirect  = 1'b1;
    br_target    = 32'h8000_0100;
    step();
    exc_redirect = 1'b0;
    br_redirect  = 1'b0;
    check("prio_pc",   pc,                  32'h8000_0180);
    check("prio_req",  {31'd0, ireq_valid}, 32'd1);

    // Misaligned target: no request, AdEL with a NOP, cleared by exception redirect.
    br_redirect = 1'b1;
    br_target   = 32'h8000_0102;
    step();
    br_redirect = 1'b0;
    stall       = 1'b1;
    check("mis_noreq", {31'd0, ireq_valid},  32'd0);
    check("mis_valid", {31'd0, instr_valid}, 32'd1);
    check("mis_adel",  {31'd0, adel},        32'd1);
    check("mis_raw",   raw_instr,            32'h0000_0000);
    check("mis_busy",  {31'd0, fetch_busy},  32'd0);
    step();
    check("mis_hold_adel", {31'd0, adel}, 32'd1);
    check("mis_hold_pc",   pc,            32'h8000_0102);
    stall        = 1'b0;
    exc_redirect = 1'b1;
    exc_target   = 32'h8000_0180;
    step();
    exc_redirect = 1'b0;
    check("mis_clr_adel", {31'd0, adel},       32'd0);
    check("mis_clr_req",  {31'd0, ireq_valid}, 32'd1);
    check("mis_clr_addr", ireq_addr,           32'h8000_0180);

    // PC wraps from the top of the address space to zero.
    exc_redirect = 1'b1;
    exc_target   = 32'hFFFF_FFFC;
    step();
    exc_redirect = 1'b0;
    check("wrap_addr", ireq_addr, 32'hFFFF_FFFC);
    fetch_word(32'h3333_3333);
    check("wrap_raw", raw_instr, 32'h3333_3333);
    step();
    check("wrap_pc",  pc,                  32'h0000_0000);
    check("wrap_req", {31'd0, ireq_valid}, 32'd1);

    // Asynchronous reset mid-transaction takes effect without a clock edge.
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pc",    pc,                  32'hBFC0_0000);
    check("async_rst_noreq", {31'd0, ireq_valid}, 32'd0);
    check("async_rst_busy",  {31'd0, fetch_busy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
